// File: rtl/motor_nn_pkg.sv
// Shared definitions for the motor MPC network datapath: fixed-point format,
// sequencer state encoding and the ReLU clamp.
package motor_nn_pkg;

    localparam int unsigned W_FIX = 32;
    localparam int unsigned I_FIX = 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        EMIT,
        DONE
    } fsm_t;

    // Positive inputs pass with the sign bit forced low; zero and negatives clamp to 0.
    function automatic logic [W_FIX-1:0] relu_fix(input logic [W_FIX-1:0] x);
        return ($signed(x) > 0) ? {1'b0, x[W_FIX-2:0]} : '0;
    endfunction

endpackage

// File: rtl/motor_relu_lane.sv
// Combinational single-element ReLU clamp; also flags elements that were clamped (x <= 0).
module motor_relu_lane
    import motor_nn_pkg::*;
#(
    parameter int unsigned W = W_FIX
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         clamped
);

    generate
        if (W == W_FIX) begin : g_fix
            assign y = relu_fix(x);
        end else begin : g_gen
            assign y = (!x[W-1] && (|x)) ? {1'b0, x[W-2:0]} : '0;
        end
    endgenerate

    assign clamped = x[W-1] | ~(|x);

endmodule

// File: rtl/motor_relu_stream_sequencer.sv
// Packs a serial element stream into LANES-wide ReLU beats, one vector at a time,
// for a batch of cfg_nvec vectors started by ap_start and closed by ap_done.
module motor_relu_stream_sequencer
    import motor_nn_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter int unsigned N_ELEM = 3,
    parameter int unsigned LANES  = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic                          ap_start,
    input  logic [CNT_W-1:0]              cfg_nvec,
    output logic                          ap_idle,
    output logic                          ap_done,
    input  logic [W-1:0]                  s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [LANES*W-1:0]            m_data,
    output logic [LANES-1:0]              m_mask,
    output logic                          m_last,
    output logic [$clog2(N_ELEM+1)-1:0]   m_neg_cnt,
    output logic                          m_valid,
    input  logic                          m_ready
);

    localparam int unsigned NEG_W = $clog2(N_ELEM + 1);
    localparam int unsigned EW    = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [EW-1:0] ELEM_END = EW'(N_ELEM - 1);
    localparam logic [LW-1:0] LANE_END = LW'(LANES - 1);

    fsm_t               state_q;
    fsm_t               state_d;
    logic [CNT_W-1:0]   nvec_q;
    logic [CNT_W-1:0]   vec_cnt;
    logic [LW-1:0]      lane_idx;
    logic [EW-1:0]      elem_idx;
    logic [NEG_W-1:0]   neg_cnt;
    logic [W-1:0]       lane_q [LANES];
    logic [LANES-1:0]   mask_q;
    logic               last_q;

    logic [W-1:0]       relu_y;
    logic               relu_neg;
    logic               accept;
    logic               close;
    logic               hs;
    logic               elem_last;
    logic               batch_end;
    logic               emit;

    motor_relu_lane #(
        .W (W)
    ) u_lane (
        .x       (s_data),
        .y       (relu_y),
        .clamped (relu_neg)
    );

    assign emit      = (state_q == EMIT);
    assign accept    = (state_q == FILL) && s_valid;
    assign elem_last = (elem_idx == ELEM_END);
    assign close     = accept && ((lane_idx == LANE_END) || elem_last);
    assign hs        = emit && m_ready;
    assign batch_end = ((vec_cnt + CNT_W'(1)) == nvec_q);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ap_idle = 1'b0;
        ap_done = 1'b0;
        s_ready = 1'b0;
        m_valid = 1'b0;
        case (state_q)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    state_d = (cfg_nvec == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                s_ready = 1'b1;
                if (close) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = (last_q && batch_end) ? DONE : FILL;
                end
            end
            DONE: begin
                ap_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            nvec_q   <= '0;
            vec_cnt  <= '0;
            lane_idx <= '0;
            elem_idx <= '0;
            neg_cnt  <= '0;
            mask_q   <= '0;
            last_q   <= 1'b0;
            for (int unsigned k = 0; k < LANES; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            if ((state_q == IDLE) && ap_start) begin
                nvec_q  <= cfg_nvec;
                vec_cnt <= '0;
            end
            if (accept) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    if (lane_idx == LW'(k)) begin
                        lane_q[k] <= relu_y;
                        mask_q[k] <= 1'b1;
                    end
                end
                neg_cnt <= neg_cnt + NEG_W'(relu_neg);
                // Indices saturate at their group/vector end so they never wrap before the handshake clears them.
                lane_idx <= close ? lane_idx : lane_idx + LW'(1);
                elem_idx <= elem_last ? elem_idx : elem_idx + EW'(1);
                if (elem_last) begin
                    last_q <= 1'b1;
                end
            end
            if (hs) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    lane_q[k] <= '0;
                end
                mask_q   <= '0;
                lane_idx <= '0;
                last_q   <= 1'b0;
                if (last_q) begin
                    elem_idx <= '0;
                    neg_cnt  <= '0;
                    vec_cnt  <= vec_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        m_data = '0;
        if (emit) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                m_data[k*W +: W] = lane_q[k];
            end
        end
    end

    assign m_mask    = emit ? mask_q : '0;
    assign m_last    = emit && last_q;
    assign m_neg_cnt = (emit && last_q) ? neg_cnt : '0;

endmodule

// File: tb/tb_motor_relu_stream_sequencer.sv
// Randomized bench for motor_relu_stream_sequencer against a vector-level ReLU/grouping model;
// a 3-element and a 5-element instance share the stream and are selected by sel.
module tb_motor_relu_stream_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ap_start;
    logic        sel;
    logic [15:0] cfg_nvec;
    logic [31:0] s_data;
    logic        s_valid;
    logic        m_ready;
    logic        start3, start5;

    logic        idle3, done3, sready3, last3, valid3;
    logic [95:0] data3;
    logic [2:0]  mask3;
    logic [1:0]  neg3;
    logic        idle5, done5, sready5, last5, valid5;
    logic [95:0] data5;
    logic [2:0]  mask5;
    logic [2:0]  neg5;

    logic        cur_idle, cur_done, cur_sready, cur_last, cur_valid;
    logic [95:0] cur_data;
    logic [2:0]  cur_mask;
    logic [2:0]  cur_neg;

    typedef struct {
        logic [95:0] data;
        logic [2:0]  mask;
        logic        last;
        int          neg;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] stim[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_hs_cyc = 0;
    int          lasts_seen  = 0;
    int          rdy_mode    = 0;

    assign start3 = ap_start & ~sel;
    assign start5 = ap_start & sel;

    assign cur_idle   = sel ? idle5   : idle3;
    assign cur_done   = sel ? done5   : done3;
    assign cur_sready = sel ? sready5 : sready3;
    assign cur_last   = sel ? last5   : last3;
    assign cur_valid  = sel ? valid5  : valid3;
    assign cur_data   = sel ? data5   : data3;
    assign cur_mask   = sel ? mask5   : mask3;
    assign cur_neg    = sel ? neg5    : {1'b0, neg3};

    motor_relu_stream_sequencer #(
        .W(32), .N_ELEM(3), .LANES(3), .CNT_W(16)
    ) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start3), .cfg_nvec(cfg_nvec),
        .ap_idle(idle3), .ap_done(done3), .s_data(s_data), .s_valid(s_valid),
        .s_ready(sready3), .m_data(data3), .m_mask(mask3), .m_last(last3),
        .m_neg_cnt(neg3), .m_valid(valid3), .m_ready(m_ready)
    );

    motor_relu_stream_sequencer #(
        .W(32), .N_ELEM(5), .LANES(3), .CNT_W(16)
    ) dut5 (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start5), .cfg_nvec(cfg_nvec),
        .ap_idle(idle5), .ap_done(done5), .s_data(s_data), .s_valid(s_valid),
        .s_ready(sready5), .m_data(data5), .m_mask(mask5), .m_last(last5),
        .m_neg_cnt(neg5), .m_valid(valid5), .m_ready(m_ready)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] relu_ref(input logic [31:0] x);
        return (int'(x) > 0) ? x : 32'd0;
    endfunction

    // Expected beats for one vector: consecutive groups of up to 3 elements.
    task automatic model_vector(input int ne, input int base);
        beat_t b;
        int    lane = 0;
        int    neg  = 0;
        b.data = '0; b.mask = '0; b.last = 1'b0; b.neg = 0;
        for (int i = 0; i < ne; i++) begin
            if (int'(stim[base+i]) <= 0) neg++;
            b.data[lane*32 +: 32] = relu_ref(stim[base+i]);
            b.mask[lane] = 1'b1;
            lane++;
            if (lane == 3 || i == ne - 1) begin
                b.last = (i == ne - 1);
                b.neg  = neg;
                exp_q.push_back(b);
                b.data = '0; b.mask = '0;
                lane = 0;
            end
        end
    endtask

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && cur_valid && m_ready) begin
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", cur_data, b.data);
                    check("beat_mask", cur_mask, b.mask);
                    check("beat_last", cur_last, b.last);
                    if (b.last) begin
                        check("beat_neg", cur_neg, b.neg);
                        lasts_seen++;
                    end
                end
            end
        end
    end

    task automatic start(input logic s, input int n);
        @(posedge clk); #1;
        sel = s; cfg_nvec = 16'(n); ap_start = 1'b1;
        @(posedge clk); #1;
        ap_start = 1'b0;
    endtask

    task automatic push_elem(input logic [31:0] x, input bit bub);
        int guard = 0;
        if (bub) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        s_data = x; s_valid = 1'b1;
        do begin
            @(negedge clk);
            guard++;
        end while (!cur_sready && guard < 300);
        if (!cur_sready) check("s_ready_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input bit had_beats);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!cur_done && guard < 2000);
        check("done_seen", cur_done, 1);
        if (had_beats) check("done_latency", cyc - last_hs_cyc, 1);
        check("beats_left", exp_q.size(), 0);
        @(negedge clk);
        check("done_pulse", cur_done, 0);
        check("idle_after", cur_idle, 1);
    endtask

    task automatic run_batch(input logic s, input int nvec, input bit bub);
        int ne = s ? 5 : 3;
        for (int v = 0; v < nvec; v++) model_vector(ne, v * ne);
        start(s, nvec);
        for (int i = 0; i < nvec * ne; i++) push_elem(stim[i], bub);
        wait_done(nvec != 0);
    endtask

    function automatic logic [31:0] rand_elem();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        rst_n = 1'b0; ap_start = 1'b0; sel = 1'b0; cfg_nvec = '0;
        s_data = '0; s_valid = 1'b0;
        #12;
        check("rst_idle", {idle3, idle5}, 2'b11);
        check("rst_valid", {valid3, valid5, done3, done5}, 4'b0);
        check("rst_sready", {sready3, sready5}, 2'b0);
        check("rst_data", {data3, mask3, last3, neg3}, '0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Mixed-sign vector, two clamps
        stim = '{32'h0000_0100, 32'hFFFF_FF00, 32'h8000_0000};
        run_batch(0, 1, 0);

        // 5-element vector splits into a full and a partial beat
        stim = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFC, 32'd5};
        run_batch(1, 1, 0);

        // Back-pressure: beat held stable, next element waits
        stim = '{32'd10, 32'hFFFF_FFFF, 32'd30, 32'd40, 32'd0, 32'd60};
        model_vector(3, 0);
        model_vector(3, 3);
        rdy_mode = 2;
        start(0, 2);
        for (int i = 0; i < 3; i++) push_elem(stim[i], 0);
        s_data = stim[3]; s_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("hold_valid", cur_valid, 1);
            check("hold_sready", cur_sready, 0);
            check("hold_data", cur_data, exp_q[0].data);
            check("hold_flags", {cur_mask, cur_last}, {exp_q[0].mask, exp_q[0].last});
        end
        rdy_mode = 0;
        for (int i = 3; i < 6; i++) push_elem(stim[i], 0);
        wait_done(1);

        // Empty batch, then ap_start inside FILL ignored
        start(0, 0);
        wait_done(0);
        stim = '{32'd7, 32'd8, 32'h8000_0001};
        model_vector(3, 0);
        start(0, 1);
        push_elem(stim[0], 0);
        cfg_nvec = 16'd5; ap_start = 1'b1;
        @(posedge clk); #1; ap_start = 1'b0;
        push_elem(stim[1], 0);
        push_elem(stim[2], 0);
        wait_done(1);
        vcount = 0;
        repeat (20) begin @(negedge clk); if (cur_valid) vcount++; end
        check("no_extra_beats", vcount, 0);

        // Reset in the middle of a vector
        stim = '{32'd11, 32'd12, 32'd13};
        start(0, 1);
        push_elem(stim[0], 0);
        push_elem(stim[1], 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_idle", cur_idle, 1);
        check("mid_rst_out", {cur_valid, cur_done, cur_sready, cur_last}, 4'b0);
        check("mid_rst_data", {cur_data, cur_mask, cur_neg}, '0);
        @(posedge clk); #1; rst_n = 1'b1;
        stim = '{32'd21, 32'hFFFF_0000, 32'd23};
        run_batch(0, 1, 0);

        // Saturation boundaries
        stim = '{32'h7FFF_FFFF, 32'h0000_0000, 32'd5};
        run_batch(0, 1, 0);

        // Random stream with random bubbles and back-pressure
        rdy_mode = 1;
        lasts_seen = 0;
        stim.delete();
        for (int i = 0; i < 12; i++) stim.push_back(rand_elem());
        run_batch(0, 4, 1);
        check("rand_lasts", lasts_seen, 4);
        stim.delete();
        for (int i = 0; i < 15; i++) stim.push_back(rand_elem());
        run_batch(1, 3, 1);
        check("rand5_lasts", lasts_seen, 7);
        rdy_mode = 0;

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
